pc_sequencer: RTL and testbench

- Owns the 10-bit program counter and sequences instruction fetch for the core.
- Each cycle it chooses between the sequential PC+4 and a redirect target. The redirect target comes from the execute stage, using the jump-target value produced by the jump generator datapath.
- On a taken redirect it flushes the younger in-flight fetch slots for a programmable number of cycles.
- It also supports halt/resume and flags bad targets.

---
 rtl/pc_sequencer.sv | 106 ++++++++++
 tb/tb_pc_sequencer.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Fetch-side program counter sequencer. It steps the PC or redirects it, runs the
// flush window after a taken control transfer, and handles halt/resume.
module pc_sequencer #(
  parameter logic [9:0] RESET_PC     = 10'h000,
  parameter int         FLUSH_CYCLES = 2,
  parameter int         CNT_W        = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_ready,
  output logic        if_valid,
  output logic [9:0]  pc,
  input  logic        ex_valid,
  input  logic [1:0]  jump,
  input  logic        cond,
  input  logic [31:0] target,
  output logic [9:0]  link_pc,
  output logic        flush,
  input  logic        halt,
  output logic        halted,
  input  logic        resume,
  output logic        tgt_err
);

  typedef enum logic [1:0] {S_BOOT, S_FETCH, S_FLUSH, S_HALT} state_t;

  typedef struct packed {
    logic       taken;
    logic       link;
    logic       bad;
    logic [9:0] pc;
  } redir_t;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             halt_pend;
  logic [9:0]       pc_plus4;
  redir_t           rd;

  assign pc_plus4 = pc + 10'd4;

  // A not-taken branch (jump=01, cond=0) and jump=00 both decode as no redirect.
  always_comb begin
    rd       = '0;
    rd.taken = ex_valid && (jump[1] || cond && jump[0]);
    rd.link  = jump[1];
    rd.bad   = (target[1:0] != 2'b00) || (target[31:10] != 22'd0);
    rd.pc    = {target[9:2], 2'b00};
  end

  assign if_valid = (state == S_FETCH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_BOOT;
      pc        <= RESET_PC;
      cnt       <= '0;
      halt_pend <= 1'b0;
      flush     <= 1'b0;
      halted    <= 1'b0;
      link_pc   <= '0;
      tgt_err   <= 1'b0;
    end else if (state == S_HALT) begin
      // A redirect in HALT is ignored; only resume leaves.
      if (resume) begin
        state     <= S_FETCH;
        halted    <= 1'b0;
        halt_pend <= 1'b0;
      end
    end else if (rd.taken) begin
      pc    <= rd.pc;
      cnt   <= CNT_LOAD;
      state <= S_FLUSH;
      flush <= 1'b1;
      if (rd.link) link_pc <= pc_plus4;
      if (rd.bad) tgt_err <= 1'b1;
      if (state == S_FLUSH && halt) halt_pend <= 1'b1;
    end else if (state == S_BOOT) begin
      state <= S_FETCH;
    end else if (state == S_FETCH) begin
      if (halt) begin
        state  <= S_HALT;
        halted <= 1'b1;
      end else if (if_ready) begin
        pc <= pc_plus4;
      end
    end else begin
      // Flush window: the counter runs FLUSH_CYCLES-1 down to 0, one cycle per value.
      if (halt) halt_pend <= 1'b1;
      if (cnt == '0) begin
        flush <= 1'b0;
        if (halt_pend || halt) begin
          state  <= S_HALT;
          halted <= 1'b1;
        end else begin
          state <= S_FETCH;
        end
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus random traffic, all checked
// against a mode/remaining-cycles model of the sequencer.
module tb_pc_sequencer;
  localparam int F = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_ready = 1'b0, ex_valid = 1'b0, cond = 1'b0, halt = 1'b0, resume = 1'b0;
  logic [1:0]  jump = 2'b00;
  logic [31:0] target = '0;
  logic        if_valid, flush, halted, tgt_err;
  logic [9:0]  pc, link_pc;

  pc_sequencer #(.RESET_PC(10'h000), .FLUSH_CYCLES(F), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .if_ready(if_ready), .if_valid(if_valid), .pc(pc),
    .ex_valid(ex_valid), .jump(jump), .cond(cond), .target(target),
    .link_pc(link_pc), .flush(flush), .halt(halt), .halted(halted),
    .resume(resume), .tgt_err(tgt_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: mode 0 boot, 1 fetch, 2 flush, 3 halt; 'left' = flush cycles still to show.
  int          m_mode, m_left;
  int unsigned m_pc, m_link;
  bit          m_err, m_pend;

  task automatic m_reset();
    m_mode = 0; m_left = 0; m_pc = 0; m_link = 0; m_err = 0; m_pend = 0;
  endtask

  task automatic m_step(input bit rdy, input bit exv, input int jp, input bit c,
                        input int unsigned tg, input bit h, input bit r);
    bit take;
    take = exv && (jp == 2 || jp == 3 || (jp == 1 && c));
    if (m_mode == 3) begin
      if (r) begin m_mode = 1; m_pend = 0; end
    end else if (take) begin
      if (m_mode == 2 && h) m_pend = 1;
      if (jp >= 2) m_link = (m_pc + 4) % 1024;
      if (tg % 4 != 0 || tg >= 1024) m_err = 1;
      m_pc = (tg % 1024) / 4 * 4;
      m_mode = 2; m_left = F;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (h) m_mode = 3;
      else if (rdy) m_pc = (m_pc + 4) % 1024;
    end else begin
      if (h) m_pend = 1;
      m_left--;
      if (m_left == 0) m_mode = m_pend ? 3 : 1;
    end
  endtask

  task automatic cmp_all();
    chk("pc", 32'(pc), m_pc);
    chk("if_valid", 32'(if_valid), 32'(m_mode == 1));
    chk("flush", 32'(flush), 32'(m_mode == 2));
    chk("halted", 32'(halted), 32'(m_mode == 3));
    chk("link_pc", 32'(link_pc), m_link);
    chk("tgt_err", 32'(tgt_err), 32'(m_err));
  endtask

  task automatic cyc(input bit rdy, input bit exv, input logic [1:0] jp, input bit c,
                     input logic [31:0] tg, input bit h, input bit r);
    if_ready = rdy; ex_valid = exv; jump = jp; cond = c; target = tg; halt = h; resume = r;
    m_step(rdy, exv, int'(jp), c, tg, h, r);
    @(negedge clk);
    cmp_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    m_reset();
    cmp_all();
    chk("rst_pc", 32'(pc), 32'h0);
    rst = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    // boot then sequential fetch
    cyc(1, 0, 2'b00, 0, 0, 0, 0); chk("boot_pc0", 32'(pc), 32'h000); chk("boot_iv", 32'(if_valid), 1);
    cyc(1, 0, 2'b00, 0, 0, 0, 0); chk("seq_pc4", 32'(pc), 32'h004);
    cyc(1, 0, 2'b00, 0, 0, 0, 0); chk("seq_pc8", 32'(pc), 32'h008);
    cyc(1, 0, 2'b00, 0, 0, 0, 0);
    cyc(1, 0, 2'b00, 0, 0, 0, 0); chk("at_10", 32'(pc), 32'h010);
    // stall
    repeat (3) cyc(0, 0, 2'b00, 0, 0, 0, 0);
    chk("stall_pc", 32'(pc), 32'h010); chk("stall_iv", 32'(if_valid), 1);
    cyc(1, 0, 2'b00, 0, 0, 0, 0); chk("unstall_pc", 32'(pc), 32'h014);
    // jal redirect overriding acceptance
    cyc(1, 1, 2'b10, 0, 32'h120, 0, 0);
    chk("jal_pc", 32'(pc), 32'h120); chk("jal_flush", 32'(flush), 1); chk("jal_link", 32'(link_pc), 32'h018);
    cyc(1, 0, 2'b00, 0, 0, 0, 0); chk("flush2", 32'(flush), 1);
    cyc(1, 0, 2'b00, 0, 0, 0, 0); chk("flush_end", 32'(flush), 0); chk("fetch_120", 32'(pc), 32'h120);
    cyc(1, 0, 2'b00, 0, 0, 0, 0); chk("fetch_124", 32'(pc), 32'h124);
    // branch not taken / taken
    cyc(1, 1, 2'b01, 0, 32'h200, 0, 0); chk("bnt_pc", 32'(pc), 32'h128);
    cyc(1, 1, 2'b01, 1, 32'h200, 0, 0); chk("bt_pc", 32'(pc), 32'h200);
    repeat (2) cyc(1, 0, 2'b00, 0, 0, 0, 0);
    // bad target on jalr
    cyc(1, 1, 2'b11, 0, 32'h402, 0, 0); chk("bad_pc", 32'(pc), 32'h000); chk("bad_err", 32'(tgt_err), 1);
    repeat (2) cyc(1, 0, 2'b00, 0, 0, 0, 0);
    // wrap
    cyc(1, 1, 2'b10, 0, 32'h3FC, 0, 0);
    repeat (2) cyc(1, 0, 2'b00, 0, 0, 0, 0); chk("at_3fc", 32'(pc), 32'h3FC);
    cyc(1, 0, 2'b00, 0, 0, 0, 0); chk("wrap", 32'(pc), 32'h000); chk("err_sticky", 32'(tgt_err), 1);
    // halt during flush, ex_valid ignored in HALT, resume
    cyc(1, 1, 2'b10, 0, 32'h080, 0, 0);
    cyc(1, 0, 2'b00, 0, 0, 1, 0); chk("flush_full", 32'(flush), 1);
    cyc(1, 0, 2'b00, 0, 0, 0, 0); chk("halted", 32'(halted), 1); chk("halt_flush", 32'(flush), 0);
    cyc(1, 1, 2'b10, 0, 32'h300, 0, 0); chk("halt_ign", 32'(pc), 32'h080);
    cyc(1, 0, 2'b00, 0, 0, 0, 1); chk("resume_pc", 32'(pc), 32'h080); chk("resume_iv", 32'(if_valid), 1);
    // reset in HALT
    cyc(1, 0, 2'b00, 0, 0, 1, 0); chk("halt2", 32'(halted), 1);
    do_reset(); chk("rst_err", 32'(tgt_err), 0); chk("rst_halted", 32'(halted), 0);
    cyc(1, 0, 2'b00, 0, 0, 0, 0);
    // random traffic
    for (int i = 0; i < 4000; i++) begin
      logic [31:0] tg;
      tg = ($urandom_range(0, 99) < 4) ? $urandom : ($urandom & 32'h3FC);
      if ($urandom_range(0, 599) == 0) begin
        @(negedge clk);
        do_reset();
      end
      cyc($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 15, 2'($urandom),
          1'($urandom), tg, $urandom_range(0, 99) < 6, $urandom_range(0, 99) < 30);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
